booth_pp_accum: RTL and testbench

// - Consumes one/two/sign group-select vectors from the booth recoder (radix-4, 17 groups, 32-bit op2) plus multiplicand op1.
// - Generates each Booth partial product and accumulates PP_PER_CYCLE of them per clock into a 64-bit product.
// - Iterative/area-reduced alternative to the single-cycle tree; sits directly downstream of booth, valid/ready on both sides.

---
 rtl/booth_pp_accum_if.sv | 47 ++++
 rtl/booth_pp_accum.sv | 216 +++++++++++++++++++++
 tb/tb_booth_pp_accum.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pp_accum_if.sv
// Handshake and data bundle between the radix-4 Booth recoder, the iterative
// partial-product accumulator and its downstream consumer.
// The master side issues operands and accepts products.
// The slave side is the accumulator block.
interface booth_pp_accum_if;

    // Upstream side: multiplicand plus recoded multiplier groups
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1;
    logic        s_or_us;
    logic [16:0] one;
    logic [16:0] two;
    logic [16:0] sign;

    // Downstream side: finished 64-bit product
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    modport master (
        output in_valid,
        output op1,
        output s_or_us,
        output one,
        output two,
        output sign,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product
    );

    modport slave (
        input  in_valid,
        input  op1,
        input  s_or_us,
        input  one,
        input  two,
        input  sign,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product
    );

endinterface

// File: rtl/booth_pp_accum.sv
// Iterative radix-4 Booth partial-product accumulator.
// The block takes the 17 one/two/sign group selects from the recoder and the
// 32-bit multiplicand. It folds PP_PER_CYCLE partial products per clock into
// a 66-bit accumulator and presents the low 64 bits as the product.
// Flow: IDLE (accept) -> ACCUM (ITER cycles) -> DONE (hold until out_ready).
// Optional feature macro: BOOTH_CHECK_EN. When it is defined, a sticky
// booth_err output flags any accepted operation whose recoding selected both
// one and two in the same group.
module booth_pp_accum #(
    parameter int PP_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_pp_accum_if.slave    bus
`ifdef BOOTH_CHECK_EN
    ,
    output logic               booth_err
`endif
);

    localparam int NUM_GROUPS = 17;

    // Number of ACCUM cycles needed to cover all groups
    localparam int ITER = (NUM_GROUPS + PP_PER_CYCLE - 1) / PP_PER_CYCLE;

    // Iteration counter only has to reach ITER-1
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    // Group index step per ACCUM cycle
    localparam logic [5:0] IDX_STEP = 6'(PP_PER_CYCLE);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // ------------------------------------------------------------------
    // State and captured operands
    // ------------------------------------------------------------------
    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [31:0]      op1_reg;
    logic             s_reg;
    logic [16:0]      one_reg;
    logic [16:0]      two_reg;
    logic [16:0]      sign_reg;
    logic [65:0]      acc_reg;
    logic [65:0]      acc_next;
    logic [5:0]       idx_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [63:0]      product_reg;

    logic             accept;
    logic             last_iter;

    // A new operation is only taken while idle; there is no bypass path
    assign accept    = (state_reg == ST_IDLE) && bus.in_valid;
    assign last_iter = (state_reg == ST_ACCUM) && (cnt_reg == CNT_LAST);

    assign bus.in_ready  = (state_reg == ST_IDLE);
    assign bus.out_valid = (state_reg == ST_DONE);
    assign bus.product   = product_reg;

    // ------------------------------------------------------------------
    // Partial-product datapath
    // ------------------------------------------------------------------
    // Multiplicand widened to 34 bits so that +/-2*op1 of either signedness
    // still fits as a two's-complement value.
    logic [33:0] mcand;

    assign mcand = s_reg ? {{2{op1_reg[31]}}, op1_reg} : {2'b00, op1_reg};

    logic [65:0] term [PP_PER_CYCLE];

    genvar gi;
    generate
        for (gi = 0; gi < PP_PER_CYCLE; gi++) begin : g_lane
            logic [6:0]  grp;
            logic [4:0]  sel;
            logic        live;
            logic [33:0] mag;
            logic [33:0] pp;

            // Group handled by this lane in the current iteration
            assign grp  = {1'b0, idx_reg} + 7'(gi);
            assign live = (grp < 7'(NUM_GROUPS));
            assign sel  = grp[4:0];

            // Select magnitude (two wins over one) then apply the group sign.
            // A negated zero magnitude wraps back to exactly zero.
            always_comb begin
                mag = '0;
                if (live) begin
                    if (two_reg[sel]) begin
                        mag = {mcand[32:0], 1'b0};
                    end else if (one_reg[sel]) begin
                        mag = mcand;
                    end
                end
                pp = (live && sign_reg[sel]) ? (~mag + 34'd1) : mag;
            end

            // Sign-extend to accumulator width and weight by 4^group
            assign term[gi] = {{32{pp[33]}}, pp} << {grp, 1'b0};
        end
    endgenerate

    // Sum this iteration's lanes into the running accumulator (mod 2^66)
    always_comb begin
        acc_next = acc_reg;
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            acc_next = acc_next + term[k];
        end
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    // Next-state selection for the IDLE/ACCUM/DONE sequence
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture operands on accept; they stay frozen for the whole operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_reg  <= '0;
            s_reg    <= 1'b0;
            one_reg  <= '0;
            two_reg  <= '0;
            sign_reg <= '0;
        end else if (accept) begin
            op1_reg  <= bus.op1;
            s_reg    <= bus.s_or_us;
            one_reg  <= bus.one;
            two_reg  <= bus.two;
            sign_reg <= bus.sign;
        end
    end

    // Accumulator, group index and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            idx_reg <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            acc_reg <= '0;
            idx_reg <= '0;
            cnt_reg <= '0;
        end else if (state_reg == ST_ACCUM) begin
            acc_reg <= acc_next;
            idx_reg <= idx_reg + IDX_STEP;
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Product register loads as DONE is entered and holds through IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_reg <= '0;
        end else if (last_iter) begin
            product_reg <= acc_next[63:0];
        end
    end

`ifdef BOOTH_CHECK_EN
    // ------------------------------------------------------------------
    // Recoding sanity check
    // ------------------------------------------------------------------
    logic err_reg;
    logic first_accum;

    // First ACCUM cycle is the one right after the accept edge
    assign first_accum = (state_reg == ST_ACCUM) && (cnt_reg == '0);

    // Sticky flag: any captured group that selected both one and two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (first_accum && |(one_reg & two_reg)) begin
            err_reg <= 1'b1;
        end
    end

    assign booth_err = err_reg;
`endif

endmodule

// File: tb/tb_booth_pp_accum.sv
// Scoreboard bench for booth_pp_accum. A radix-4 recoder function stands in
// for the upstream booth block. The driver pushes hand-computed products
// into a queue, and a monitor pops and compares them on each new output.
module tb_booth_pp_accum;

    localparam int PP   = 1;
    localparam int ITER = (17 + PP - 1) / PP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    booth_pp_accum_if bus_if ();

`ifdef BOOTH_CHECK_EN
    logic booth_err;
`endif

    booth_pp_accum #(
        .PP_PER_CYCLE(PP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
`ifdef BOOTH_CHECK_EN
        ,
        .booth_err (booth_err)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] prod;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Radix-4 Booth recoding of op2 into 17 groups (bit -1 = 0)
    function automatic void booth_rec(input logic [31:0] b, input logic s,
                                      output logic [16:0] o, output logic [16:0] t,
                                      output logic [16:0] g);
        logic [34:0] x;
        logic [2:0]  w;
        x = {(s ? {2{b[31]}} : 2'b00), b, 1'b0};
        o = '0;
        t = '0;
        g = '0;
        for (int i = 0; i < 17; i++) begin
            w = x[2*i+2 -: 3];
            case (w)
                3'b001, 3'b010, 3'b101, 3'b110: o[i] = 1'b1;
                3'b011, 3'b100:                 t[i] = 1'b1;
                default:                        ;
            endcase
            g[i] = w[2];
        end
    endfunction

    // Issue one operation with raw group selects; push expectation if asked
    task automatic send_raw(input string name, input logic [31:0] a, input logic s,
                            input logic [16:0] o, input logic [16:0] t, input logic [16:0] g,
                            input logic [63:0] exp, input bit push);
        int n;
        @(negedge clk);
        bus_if.op1      = a;
        bus_if.s_or_us  = s;
        bus_if.one      = o;
        bus_if.two      = t;
        bus_if.sign     = g;
        bus_if.in_valid = 1'b1;
        n = 0;
        while (!bus_if.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout actual=in_ready_low required=in_ready_high", name);
            bus_if.in_valid = 1'b0;
        end else begin
            if (push) sb.push_back('{exp, cyc + 1, name});
            @(negedge clk);
            bus_if.in_valid = 1'b0;
            // Scramble inputs: captured copies must be unaffected
            bus_if.op1     = ~a;
            bus_if.s_or_us = ~s;
            bus_if.one     = ~o;
            bus_if.two     = ~t;
            bus_if.sign    = ~g;
        end
    endtask

    task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp, input bit push);
        logic [16:0] o, t, g;
        booth_rec(b, s, o, t, g);
        send_raw(name, a, s, o, t, g, exp, push);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !bus_if.in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    // Monitor: compare product and latency whenever a new result appears
    initial begin : monitor
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus_if.out_valid && !prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none", bus_if.product);
                end else begin
                    e = sb.pop_front();
                    chk(e.name, bus_if.product, e.prod);
                    chk({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'(ITER));
                    $display("txn %s product=%h latency=%0d", e.name, bus_if.product, cyc - e.acc_cyc);
                end
            end
            prev = rst_n && bus_if.out_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus_if.in_valid  = 1'b0;
        bus_if.op1       = '0;
        bus_if.s_or_us   = 1'b0;
        bus_if.one       = '0;
        bus_if.two       = '0;
        bus_if.sign      = '0;
        bus_if.out_ready = 1'b1;
        rst_n            = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_product", bus_if.product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("rst_out_valid_after", 64'(bus_if.out_valid), 64'd0);
`ifdef BOOTH_CHECK_EN
        chk("rst_booth_err", 64'(booth_err), 64'd0);
`endif

        // Directed vectors, products computed by hand
        run_vec("u_max",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
        run_vec("s_m1_x2",    32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b1);
        run_vec("s_min_sq",   32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1);
        run_vec("u_msb_x2",   32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000, 1'b1);
        run_vec("s_3_m5",     32'h00000003, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFFFFFFFFF1, 1'b1);
        run_vec("u_3_big",    32'h00000003, 32'hFFFFFFFB, 1'b0, 64'h00000002FFFFFFF1, 1'b1);
        run_vec("u_2p16_sq",  32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, 1'b1);
        run_vec("s_max_sq",   32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001, 1'b1);
        run_vec("s_min_max",  32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000, 1'b1);
        run_vec("s_zero",     32'h00000000, 32'h12345678, 1'b1, 64'h0000000000000000, 1'b1);
        run_vec("u_times1",   32'h12345678, 32'h00000001, 1'b0, 64'h0000000012345678, 1'b1);
        run_vec("s_m2_m3",    32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 64'h0000000000000006, 1'b1);
        run_vec("u_ffff_sq",  32'h0000FFFF, 32'h0000FFFF, 1'b0, 64'h00000000FFFE0001, 1'b1);
        wait_idle();

        // Backpressure: hold DONE for five cycles with in_valid pulses
        bus_if.out_ready = 1'b0;
        run_vec("bp_u_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
        begin
            int n;
            n = 0;
            while (!bus_if.out_valid && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (n >= 60) begin
                checks++;
                errors++;
                $display("FAIL bp_done_timeout actual=out_valid_low required=out_valid_high");
            end
        end
        for (int c = 0; c < 5; c++) begin
            bus_if.in_valid = (c == 1 || c == 3);
            bus_if.op1      = 32'h00000005;
            bus_if.s_or_us  = 1'b0;
            bus_if.one      = 17'h00001;
            bus_if.two      = 17'h00000;
            bus_if.sign     = 17'h00000;
            @(negedge clk);
            chk("bp_out_valid", 64'(bus_if.out_valid), 64'd1);
            chk("bp_product", bus_if.product, 64'hFFFFFFFE00000001);
            chk("bp_in_ready", 64'(bus_if.in_ready), 64'd0);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("idle_product_hold", bus_if.product, 64'hFFFFFFFE00000001);

        // Reset abort during the eighth ACCUM cycle
        run_vec("rst_abort", 32'h12345678, 32'h9ABCDEF0, 1'b0, 64'd0, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("abort_product", bus_if.product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("abort_out_valid_after", 64'(bus_if.out_valid), 64'd0);

        run_vec("post_rst", 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 64'h0000000000000006, 1'b1);
        wait_idle();
`ifdef BOOTH_CHECK_EN
        chk("legal_booth_err", 64'(booth_err), 64'd0);
`endif

        // Illegal recoding: group 3 selects one and two, two wins: 3*2*4^3
        send_raw("illegal_g3", 32'h00000003, 1'b0, 17'h00008, 17'h00008, 17'h00000,
                 64'h0000000000000180, 1'b1);
        wait_idle();
`ifdef BOOTH_CHECK_EN
        chk("illegal_booth_err", 64'(booth_err), 64'd1);
`endif
        run_vec("after_err_1", 32'h00000007, 32'h00000006, 1'b0, 64'h000000000000002A, 1'b1);
        wait_idle();
`ifdef BOOTH_CHECK_EN
        chk("sticky_booth_err_1", 64'(booth_err), 64'd1);
`endif
        run_vec("after_err_2", 32'hFFFFFFF9, 32'h00000006, 1'b1, 64'hFFFFFFFFFFFFFFD6, 1'b1);
        wait_idle();
`ifdef BOOTH_CHECK_EN
        chk("sticky_booth_err_2", 64'(booth_err), 64'd1);
`endif

        repeat (ITER + 5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
